// File: rtl/bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_responder_pkg
// Description : Shared constants and FSM state encoding for bus_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_responder_pkg;

    localparam int BURST_LEN     = 8;
    localparam int WRITE_TAG_BIT = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRESP = 3'd2,
        RWAIT = 3'd3,
        RDATA = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : bus_responder_mem
// Description : Single-port synchronous RAM, one-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_responder_mem #(
    parameter int DEPTH      = 512,
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately left unreset so they survive a bus reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_responder
// Description : Line-burst bus target: 8-beat writes with one response beat,
//               8-beat reads after a fixed latency, backed by a local RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int DEPTH          = 512,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_BEAT_W = $clog2(BURST_LEN);
    localparam int c_LW     = c_AW - c_BEAT_W;
    localparam int c_WAIT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
        c_WAIT_W'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_ready;
    logic [c_BEAT_W-1:0]        r_beat;
    logic [c_WAIT_W-1:0]        r_wait;
    logic [c_LW-1:0]            r_line;
    logic [BUS_TAG_WIDTH-1:0]   r_tag;
    logic [c_LW-1:0]            w_req_line;
    logic                       w_req_xfer;
    logic                       w_resp_xfer;
    logic                       w_mem_we;
    logic [c_AW-1:0]            w_mem_addr;
    logic [BUS_DATA_WIDTH-1:0]  w_mem_rdata;

    // Line index only; byte offset and beat bits are dropped, upper bits wrap.
    assign w_req_line = bus_req[c_AW+2:3+c_BEAT_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_line  <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ready <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_req_xfer) begin
                        r_line <= w_req_line;
                        r_tag  <= bus_reqtag;
                        r_beat <= '0;
                        r_wait <= '0;
                    end
                end
                WDATA: begin
                    if (w_req_xfer) begin
                        r_beat <= r_beat + c_BEAT_W'(1);
                    end
                end
                RWAIT: begin
                    r_wait <= r_wait + c_WAIT_W'(1);
                end
                RDATA: begin
                    if (w_resp_xfer) begin
                        r_beat <= r_beat + c_BEAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus_reqack   = r_ready && ((r_state == IDLE) || (r_state == WDATA));
        bus_respcyc  = (r_state == WRESP) || (r_state == RDATA);
        bus_resp     = '0;
        bus_resptag  = '0;
        w_req_xfer   = bus_reqcyc && bus_reqack;
        w_resp_xfer  = bus_respcyc && bus_respack;
        w_mem_we     = 1'b0;
        w_mem_addr   = {r_line, r_beat};

        case (r_state)
            IDLE: begin
                // Prefetch beat 0 so a latency of 1 still has data in time.
                w_mem_addr = {w_req_line, c_BEAT_W'(0)};
                if (w_req_xfer) begin
                    if (bus_reqtag[WRITE_TAG_BIT]) begin
                        w_state_next = WDATA;
                    end else if (READ_LATENCY == 1) begin
                        w_state_next = RDATA;
                    end else begin
                        w_state_next = RWAIT;
                    end
                end
            end
            WDATA: begin
                w_mem_we = w_req_xfer;
                if (w_req_xfer && (r_beat == c_LAST_BEAT)) begin
                    w_state_next = WRESP;
                end
            end
            WRESP: begin
                bus_resptag = r_tag;
                if (w_resp_xfer) begin
                    w_state_next = IDLE;
                end
            end
            RWAIT: begin
                if (r_wait == c_WAIT_LAST) begin
                    w_state_next = RDATA;
                end
            end
            RDATA: begin
                bus_resp    = w_mem_rdata;
                bus_resptag = r_tag;
                // Re-reading the current beat while stalled keeps bus_resp stable.
                if (w_resp_xfer) begin
                    w_mem_addr = {r_line, r_beat + c_BEAT_W'(1)};
                    if (r_beat == c_LAST_BEAT) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    bus_responder_mem #(
        .DEPTH      (DEPTH),
        .WIDTH      (BUS_DATA_WIDTH),
        .ADDR_WIDTH (c_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (bus_req),
        .o_rdata (w_mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_responder
// Description : Directed self-checking bench for bus_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_responder;

    localparam int DW = 64;
    localparam int TW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          bus_reqcyc = 1'b0;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] rd_data [8];
    logic [TW-1:0] rd_tag [8];
    int            rd_lat;
    int            rd_beats;
    int            rd_ack_during;
    bit            rd_stall_ok;
    logic          rd_ack_after;

    int            wr_cycles;
    logic          wr_resp_seen;
    logic [DW-1:0] wr_resp;
    logic [TW-1:0] wr_resp_tag;
    bit            wr_hold_ok;
    logic          wr_after;

    bus_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .DEPTH          (512),
        .READ_LATENCY   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request beat plus n_data data beats; full bursts also collect the response.
    task automatic do_write(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                            input logic [DW-1:0] d [8], input int n_data);
        int i;
        int w;
        i = 0;
        wr_cycles = 0;
        wr_resp_seen = 1'b0;
        while (i <= n_data && wr_cycles < 40) begin
            bus_reqcyc = 1'b1;
            bus_reqtag = tag;
            bus_req    = (i == 0) ? addr : d[i-1];
            if (bus_reqack) i++;
            step();
            wr_cycles++;
        end
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        if (n_data < 8) return;
        w = 0;
        while (!bus_respcyc && w < 20) begin
            step();
            w++;
        end
        wr_resp_seen = bus_respcyc;
        wr_resp      = bus_resp;
        wr_resp_tag  = bus_resptag;
        wr_hold_ok   = 1'b1;
        repeat (2) begin
            step();
            if (!bus_respcyc || bus_resp !== wr_resp || bus_resptag !== wr_resp_tag)
                wr_hold_ok = 1'b0;
        end
        bus_respack = 1'b1;
        step();
        bus_respack = 1'b0;
        wr_after = bus_respcyc;
    endtask

    task automatic do_read(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                           input int stall_beat, input int stall_cycles,
                           input bit hold_req, input logic [DW-1:0] next_addr,
                           input logic [TW-1:0] next_tag);
        int guard;
        int b;
        int sc;
        int lat;
        logic [DW-1:0] sd;
        logic [TW-1:0] st;
        guard = 0; b = 0; sc = 0;
        sd = '0; st = '0;
        rd_lat = -1; rd_beats = 0; rd_ack_during = 0; rd_stall_ok = 1'b1;
        rd_ack_after = 1'b0;
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        while (!bus_reqack && guard < 20) begin
            step();
            guard++;
        end
        if (!bus_reqack) begin
            bus_reqcyc = 1'b0;
            return;
        end
        step();
        if (hold_req) begin
            bus_req    = next_addr;
            bus_reqtag = next_tag;
        end else begin
            bus_reqcyc = 1'b0;
        end
        lat = 1;
        while (!bus_respcyc && lat < 20) begin
            if (bus_reqack) rd_ack_during++;
            step();
            lat++;
        end
        if (!bus_respcyc) return;
        rd_lat = lat;
        guard = 0;
        while (b < 8 && guard < 60) begin
            if (bus_reqack) rd_ack_during++;
            if (b == stall_beat && sc < stall_cycles) begin
                bus_respack = 1'b0;
                if (sc == 0) begin
                    sd = bus_resp;
                    st = bus_resptag;
                end else if (!bus_respcyc || bus_resp !== sd || bus_resptag !== st) begin
                    rd_stall_ok = 1'b0;
                end
                sc++;
            end else begin
                bus_respack = 1'b1;
                if (bus_respcyc) begin
                    if (b == stall_beat && stall_cycles > 0 && bus_resp !== sd)
                        rd_stall_ok = 1'b0;
                    rd_data[b] = bus_resp;
                    rd_tag[b]  = bus_resptag;
                    b++;
                end
            end
            step();
            guard++;
        end
        bus_respack  = 1'b0;
        rd_beats     = b;
        rd_ack_after = bus_reqack;
    endtask

    function automatic logic [DW-1:0] line_val(input int sel, input int i);
        case (sel)
            0: line_val = 64'(8'h11 * (i + 1));
            1: line_val = 64'hCAFE_0000_0000_0000 + 64'(i);
            2: line_val = 64'hBEEF_0000_0000_0000 + 64'(i);
            default: line_val = 64'hDEAD_0000_0000_0000 + 64'(i);
        endcase
    endfunction

    // Compares the last read burst against expected words and tag.
    task automatic test_burst_data(input string name, input logic [DW-1:0] exp_d [8],
                                   input logic [TW-1:0] exp_tag);
        bit tag_ok;
        tag_ok = 1'b1;
        checks++;
        if (rd_beats !== 8) begin
            failures++;
            $display("FAIL %s_beats: got %0d expected 8", name, rd_beats);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data[i] !== exp_d[i]) begin
                failures++;
                $display("FAIL %s_beat%0d: got %h expected %h", name, i, rd_data[i], exp_d[i]);
            end
            if (rd_tag[i] !== exp_tag) tag_ok = 1'b0;
        end
        checks++;
        if (!tag_ok) begin
            failures++;
            $display("FAIL %s_tag: got %h expected %h", name, rd_tag[0], exp_tag);
        end
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({bus_reqack, bus_respcyc, bus_resp, bus_resptag} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b cyc=%b resp=%h tag=%h expected all 0",
                     bus_reqack, bus_respcyc, bus_resp, bus_resptag);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus_reqack !== 1'b0) begin
            failures++;
            $display("FAIL reqack_before_edge: got %b expected 0", bus_reqack);
        end
        step();
        checks++;
        if (bus_reqack !== 1'b1) begin
            failures++;
            $display("FAIL reqack_after_edge: got %b expected 1", bus_reqack);
        end
    endtask

    task automatic test_write();
        logic [DW-1:0] d [8];
        for (int i = 0; i < 8; i++) d[i] = line_val(0, i);
        do_write(64'h40, 13'h1001, d, 8);
        checks++;
        if (wr_cycles !== 9) begin
            failures++;
            $display("FAIL write_ack_cycles: got %0d expected 9", wr_cycles);
        end
        checks++;
        if (wr_resp_seen !== 1'b1 || wr_resp !== '0 || wr_resp_tag !== 13'h1001) begin
            failures++;
            $display("FAIL write_resp: got cyc=%b resp=%h tag=%h expected 1/0/1001",
                     wr_resp_seen, wr_resp, wr_resp_tag);
        end
        checks++;
        if (!wr_hold_ok || wr_after !== 1'b0) begin
            failures++;
            $display("FAIL write_resp_hold: got hold=%b after=%b expected 1/0", wr_hold_ok, wr_after);
        end
    endtask

    task automatic test_read_latency();
        logic [DW-1:0] e [8];
        for (int i = 0; i < 8; i++) e[i] = line_val(0, i);
        do_read(64'h40, 13'h0005, -1, 0, 1'b0, '0, '0);
        checks++;
        if (rd_lat !== 4) begin
            failures++;
            $display("FAIL read_latency: got %0d expected 4", rd_lat);
        end
        test_burst_data("read", e, 13'h0005);
    endtask

    task automatic test_stall();
        logic [DW-1:0] e [8];
        for (int i = 0; i < 8; i++) e[i] = line_val(0, i);
        do_read(64'h40, 13'h0007, 2, 3, 1'b0, '0, '0);
        checks++;
        if (!rd_stall_ok) begin
            failures++;
            $display("FAIL stall_hold: got unstable beat expected stable %h", e[2]);
        end
        test_burst_data("stall", e, 13'h0007);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w [8];
        logic [DW-1:0] x [8];
        for (int i = 0; i < 8; i++) begin
            w[i] = line_val(1, i);
            x[i] = line_val(2, i);
        end
        do_write(64'h8040, 13'h1003, w, 8);
        do_write(64'h80, 13'h1004, x, 8);
        do_read(64'h0040, 13'h0011, -1, 0, 1'b0, '0, '0);
        test_burst_data("wrap", w, 13'h0011);
        do_read(64'h48, 13'h0012, -1, 0, 1'b0, '0, '0);
        test_burst_data("align", w, 13'h0012);
        do_read(64'h80, 13'h0013, -1, 0, 1'b0, '0, '0);
        test_burst_data("other_line", x, 13'h0013);
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] n [8];
        logic [DW-1:0] e [8];
        logic seen;
        for (int i = 0; i < 8; i++) begin
            n[i] = line_val(3, i);
            e[i] = (i < 3) ? line_val(3, i) : line_val(1, i);
        end
        do_write(64'h40, 13'h1002, n, 3);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus_reqack, bus_respcyc, bus_resp, bus_resptag} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got ack=%b cyc=%b resp=%h tag=%h expected all 0",
                     bus_reqack, bus_respcyc, bus_resp, bus_resptag);
        end
        step();
        step();
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (bus_respcyc) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_resp: got respcyc=%b expected 0", seen);
        end
        do_read(64'h40, 13'h0020, -1, 0, 1'b0, '0, '0);
        test_burst_data("partial_line", e, 13'h0020);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e [8];
        for (int i = 0; i < 8; i++) e[i] = (i < 3) ? line_val(3, i) : line_val(1, i);
        do_read(64'h40, 13'h0009, -1, 0, 1'b1, 64'h40, 13'h000A);
        checks++;
        if (rd_ack_during !== 0) begin
            failures++;
            $display("FAIL busy_reqack: got %0d acks expected 0", rd_ack_during);
        end
        checks++;
        if (rd_ack_after !== 1'b1) begin
            failures++;
            $display("FAIL next_accept: got reqack=%b expected 1", rd_ack_after);
        end
        test_burst_data("b2b_first", e, 13'h0009);
        do_read(64'h40, 13'h000A, -1, 0, 1'b0, '0, '0);
        checks++;
        if (rd_lat !== 4) begin
            failures++;
            $display("FAIL b2b_latency: got %0d expected 4", rd_lat);
        end
        test_burst_data("b2b_second", e, 13'h000A);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_latency();
        test_stall();
        test_wrap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
